d_cache_fill_fsm: RTL and testbench

- Miss handler sitting directly upstream of the data cache. On a miss it fetches the 16-byte block (8 x 16-bit words) from multi-cycle main memory.
- It drives the cache's write enables, one-hot block and word selects, fill data and new tag, then releases the pipeline stall.
- Memory is pipelined with a fixed 4-cycle read latency.

---
 rtl/d_cache_fill_fsm.sv | 136 +++++++++++++
 tb/tb_d_cache_fill_fsm.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_cache_fill_fsm.sv
// Data-cache miss handler: fetches an 8-word block from pipelined memory and writes it into the victim way.
// Optional D_CACHE_MISS_COUNT_EN adds a saturating miss_count output.
module d_cache_fill_fsm #(
    parameter int MEM_LATENCY     = 4,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic        victim_way,
    input  logic        mem_data_valid,
    input  logic [15:0] mem_data,
    output logic        fsm_busy,
    output logic        mem_en,
    output logic [15:0] mem_address,
    output logic        write_en_0,
    output logic        write_en_1,
    output logic        write_tag,
    output logic [7:0]  tag_out,
    output logic [63:0] block_en,
    output logic [7:0]  word,
    output logic [15:0] data_out
`ifdef D_CACHE_MISS_COUNT_EN
    ,
    output logic [15:0] miss_count
`endif
);

    typedef enum logic {IDLE, FILL} state_t;

    state_t      state, state_nxt;
    logic [3:0]  issue_cnt, issue_cnt_nxt;
    logic [2:0]  recv_cnt, recv_cnt_nxt;
    logic [11:0] blk_q;
    logic        way_q;
    logic        start_fill;

    // The byte offset within the block never matters: fills are always whole blocks.
    logic unused_offset;
    assign unused_offset = ^miss_address[3:0];

    assign start_fill = (state == IDLE) && miss_detected;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            issue_cnt <= issue_cnt_nxt;
            recv_cnt  <= recv_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (start_fill) begin
            blk_q <= miss_address[15:4];
            way_q <= victim_way;
        end
    end

    always_comb begin
        state_nxt     = state;
        issue_cnt_nxt = issue_cnt;
        recv_cnt_nxt  = recv_cnt;
        fsm_busy      = 1'b0;
        mem_en        = 1'b0;
        mem_address   = '0;
        write_en_0    = 1'b0;
        write_en_1    = 1'b0;
        write_tag     = 1'b0;
        tag_out       = '0;
        block_en      = '0;
        word          = '0;
        data_out      = '0;
        case (state)
            IDLE: begin
                if (miss_detected) begin
                    state_nxt     = FILL;
                    issue_cnt_nxt = '0;
                    recv_cnt_nxt  = '0;
                end
            end
            FILL: begin
                fsm_busy = 1'b1;
                if (issue_cnt < 4'(WORDS_PER_BLOCK)) begin
                    mem_en        = 1'b1;
                    mem_address   = {blk_q, issue_cnt[2:0], 1'b0};
                    issue_cnt_nxt = issue_cnt + 4'd1;
                end
                // Writes are combinational so each word lands on the same edge it arrives.
                if (mem_data_valid) begin
                    data_out     = mem_data;
                    word         = 8'b1 << recv_cnt;
                    block_en     = 64'b1 << blk_q[5:0];
                    write_en_0   = ~way_q;
                    write_en_1   = way_q;
                    recv_cnt_nxt = recv_cnt + 3'd1;
                    if (recv_cnt == 3'(WORDS_PER_BLOCK - 1)) begin
                        write_tag     = 1'b1;
                        tag_out       = {1'b1, 1'b0, blk_q[11:6]};
                        state_nxt     = IDLE;
                        issue_cnt_nxt = '0;
                        recv_cnt_nxt  = '0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef D_CACHE_MISS_COUNT_EN
    logic [15:0] miss_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_count_q <= '0;
        end else if (start_fill && (miss_count_q != 16'hFFFF)) begin
            miss_count_q <= miss_count_q + 16'd1;
        end
    end

    assign miss_count = miss_count_q;
`endif

`ifndef SYNTHESIS
    // Every word received during a fill must answer a read issued MEM_LATENCY cycles earlier.
    ap_valid_has_read: assert property (@(posedge clk) disable iff (rst)
        (state == FILL && mem_data_valid) |-> ({1'b0, recv_cnt} < issue_cnt));
    ap_valid_latency: assert property (@(posedge clk) disable iff (rst)
        (state == FILL && mem_data_valid) |-> $past(mem_en, MEM_LATENCY));
`endif

endmodule

// File: tb/tb_d_cache_fill_fsm.sv
// Scoreboard bench for d_cache_fill_fsm: a memory model returns words MEM_LATENCY cycles after each read.
module tb_d_cache_fill_fsm;
    localparam int MEM_LATENCY = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = '0;
    logic        victim_way = 1'b0;
    logic        mem_data_valid = 1'b0;
    logic [15:0] mem_data = '0;
    logic        fsm_busy, mem_en, write_en_0, write_en_1, write_tag;
    logic [15:0] mem_address, data_out;
    logic [7:0]  tag_out, word;
    logic [63:0] block_en;
`ifdef D_CACHE_MISS_COUNT_EN
    logic [15:0] miss_count;
`endif

    always #5 clk = ~clk;

    d_cache_fill_fsm #(.MEM_LATENCY(MEM_LATENCY), .WORDS_PER_BLOCK(8)) dut (
        .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
        .victim_way(victim_way), .mem_data_valid(mem_data_valid), .mem_data(mem_data),
        .fsm_busy(fsm_busy), .mem_en(mem_en), .mem_address(mem_address),
        .write_en_0(write_en_0), .write_en_1(write_en_1), .write_tag(write_tag),
        .tag_out(tag_out), .block_en(block_en), .word(word), .data_out(data_out)
`ifdef D_CACHE_MISS_COUNT_EN
        , .miss_count(miss_count)
`endif
    );

    typedef struct {
        bit          way;
        int          set;
        int          idx;
        logic [15:0] data;
        bit          last;
        logic [7:0]  tagv;
    } wr_t;

    typedef struct {
        int          due;
        logic [15:0] data;
    } ret_t;

    logic [15:0] exp_rd[$];
    wr_t         exp_wr[$];
    ret_t        rq[$];
    logic [15:0] mem_arr [32768];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          wr_seen = 0;
    int          miss_model = 0;
    bit          spur_ok = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory: pipelined, fixed latency; may present stray valids while nothing is outstanding.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                mem_data_valid = 1'b1;
                mem_data       = rq[0].data;
                void'(rq.pop_front());
            end else if (spur_ok && rq.size() == 0 && $urandom_range(0, 1) == 1) begin
                mem_data_valid = 1'b1;
                mem_data       = 16'($urandom);
            end else begin
                mem_data_valid = 1'b0;
                mem_data       = 16'($urandom);
            end
            @(negedge clk);
            if (mem_en && !rst)
                rq.push_back('{cyc + MEM_LATENCY, mem_arr[mem_address[15:1]]});
        end
    end

    // Monitor: pops the scoreboard whenever the DUT issues a read or writes the cache.
    initial begin
        logic [15:0] ea;
        wr_t         w;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("reset_ctl", {fsm_busy, mem_en, write_en_0, write_en_1, write_tag}, 0);
                check("reset_addr_tag_word_data", {mem_address, tag_out, word, data_out}, 0);
                check("reset_block_en", block_en, 0);
            end else begin
                if (mem_en) begin
                    if (exp_rd.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_read: addr %h issued, none expected", mem_address);
                    end else begin
                        ea = exp_rd.pop_front();
                        check("rd_addr", mem_address, ea);
                    end
                end
                if (write_en_0 || write_en_1 || write_tag) begin
                    if (exp_wr.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: we0=%b we1=%b wtag=%b, none expected",
                                 write_en_0, write_en_1, write_tag);
                    end else begin
                        w = exp_wr.pop_front();
                        check("wr_way", {write_en_1, write_en_0}, w.way ? 2'b10 : 2'b01);
                        check("wr_block_en", block_en, 64'd1 << w.set);
                        check("wr_word", word, 8'd1 << w.idx);
                        check("wr_data", data_out, w.data);
                        check("wr_tag_strobe", write_tag, w.last);
                        if (w.last) check("wr_tag_out", tag_out, w.tagv);
                        wr_seen++;
                    end
                end
            end
        end
    end

    task automatic push_expect(input logic [15:0] addr, input bit way);
        logic [15:0] base;
        int          set;
        logic [7:0]  tagv;
        base = addr & 16'hFFF0;
        set  = int'((addr >> 4) & 16'h003F);
        tagv = 8'h80 | 8'(addr >> 10);
        for (int i = 0; i < 8; i++) begin
            exp_rd.push_back(base + 16'(2 * i));
            exp_wr.push_back('{way, set, i, mem_arr[(base >> 1) + 16'(i)], (i == 7), tagv});
        end
    endtask

    // Called on a negedge with the DUT idle; returns on the first idle negedge after the fill.
    task automatic do_miss(input logic [15:0] addr, input bit way, input bit interfere);
        int n;
        push_expect(addr, way);
        spur_ok       = 1'b0;
        miss_detected = 1'b1;
        miss_address  = addr;
        victim_way    = way;
        check("busy_in_miss_cycle", fsm_busy, 0);
        @(negedge clk);
        miss_detected = 1'b0;
        miss_address  = 16'($urandom);
        victim_way    = 1'($urandom);
        miss_model    = (miss_model == 65535) ? 65535 : miss_model + 1;
        n = 0;
        while (fsm_busy && n < 40) begin
            if (interfere && n == 2) begin
                miss_detected = 1'b1;
                miss_address  = addr ^ 16'h5550;
                victim_way    = ~way;
            end
            if (interfere && n == 5) miss_detected = 1'b0;
            n++;
            @(negedge clk);
        end
        miss_detected = 1'b0;
        check("busy_cycles", n, 12);
        check("reads_outstanding", exp_rd.size(), 0);
        check("writes_outstanding", exp_wr.size(), 0);
    endtask

    task automatic reset_mid_fill(input logic [15:0] addr, input bit way);
        int n;
        int target;
        target = wr_seen + 3;
        push_expect(addr, way);
        spur_ok       = 1'b0;
        miss_detected = 1'b1;
        miss_address  = addr;
        victim_way    = way;
        @(negedge clk);
        miss_detected = 1'b0;
        n = 0;
        while (wr_seen < target && n < 40) begin
            @(posedge clk);
            n++;
        end
        check("words_before_reset", wr_seen, target);
        #2;
        rst = 1'b1;
        exp_rd.delete();
        exp_wr.delete();
        miss_model = 0;
        #1;
        check("async_reset_ctl", {fsm_busy, mem_en, write_en_0, write_en_1, write_tag}, 0);
        check("async_reset_data", {mem_address, word, data_out}, 0);
        check("async_reset_block_en", block_en, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check("busy_after_reset", fsm_busy, 0);
        end
        check("late_returns_drained", rq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        for (int i = 0; i < 32768; i++) mem_arr[i] = 16'($urandom);
        for (int i = 0; i < 8; i++) mem_arr[(16'hA5C0 >> 1) + i] = 16'h1000 + 16'(i);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy_after_reset", fsm_busy, 0);

        do_miss(16'hA5C6, 1'b1, 1'b0);
        @(negedge clk);
        do_miss(16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        do_miss(16'h1234, 1'b0, 1'b1);
        @(negedge clk);
        reset_mid_fill(16'h3C48, 1'b1);
        do_miss(16'h0010, 1'b0, 1'b0);
        do_miss(16'h0420, 1'b1, 1'b0);

        repeat (20) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                spur_ok = 1'b1;
                @(negedge clk);
            end
            do_miss(16'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
        end

`ifdef D_CACHE_MISS_COUNT_EN
        check("miss_count", miss_count, 16'(miss_model));
        @(negedge clk);
        rst = 1'b1;
        miss_model = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        repeat (3) do_miss(16'($urandom), 1'($urandom), 1'b0);
        check("miss_count_three", miss_count, 16'd3);
        force dut.miss_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.miss_count_q;
        repeat (2) do_miss(16'($urandom), 1'($urandom), 1'b0);
        check("miss_count_saturate", miss_count, 16'hFFFF);
`endif

        spur_ok = 1'b0;
        repeat (4) @(negedge clk);
        check("final_reads_left", exp_rd.size(), 0);
        check("final_writes_left", exp_wr.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
